// File: rtl/core_pkg.sv
// core_pkg: shared opcode encoding, field widths and sequencer state codes
package core_pkg;
  localparam int INST_W = 9;
  localparam int OP_W = 4;
  localparam int REG_W = 4;
  localparam int DATA_W = 8;
  typedef enum logic [OP_W-1:0] {
    OP_TAKE, OP_PUT, OP_LOAD, OP_STORE, OP_XOR, OP_NAND, OP_SHL, OP_SHR,
    OP_LOOKUP, OP_LSN, OP_EQL, OP_ADD, OP_SUB, OP_OF0, OP_HALT, OP_TBA
  } opcode_e;
  localparam logic [15:0] ACC_OP_MASK = 16'h1FF1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
endpackage

// File: rtl/ctrl_decode_if.sv
// ctrl_decode_if: ROM, ALU, register-file and data-memory signals of the sequencer (err only with CTRL_ILLEGAL_TRAP_EN)
interface ctrl_decode_if import core_pkg::*; #(parameter int PC_W = 8);
  logic start;
  logic [PC_W-1:0] inst_addr;
  logic [INST_W-1:0] inst_in;
  logic [DATA_W-1:0] acc_in;
  logic [OP_W-1:0] alu_op;
  logic type_bit;
  logic [REG_W-1:0] reg_sel;
  logic ovf;
  logic alu_ovf_in;
  logic acc_we;
  logic reg_we;
  logic mem_req;
  logic mem_we;
  logic mem_ack;
  logic done;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err;
`endif
  modport master (
    input start, inst_in, acc_in, alu_ovf_in, mem_ack,
    output inst_addr, alu_op, type_bit, reg_sel, ovf, acc_we, reg_we, mem_req, mem_we, done
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output err
`endif
  );
  modport slave (
    output start, inst_in, acc_in, alu_ovf_in, mem_ack,
    input inst_addr, alu_op, type_bit, reg_sel, ovf, acc_we, reg_we, mem_req, mem_we, done
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input err
`endif
  );
endinterface

// File: rtl/ctrl_pc.sv
// ctrl_pc: program counter with clear, increment and wrapping signed relative add
module ctrl_pc #(parameter int PC_W = 8) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic en,
  input logic br,
  input logic [7:0] off,
  output logic [PC_W-1:0] pc
);
  localparam int W = (PC_W > 8) ? PC_W : 8;
  logic [W-1:0] off_x;
  assign off_x = W'($signed(off));
  // PC advances by one or by the sign-extended offset, wrapping modulo 2^PC_W
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (clr) pc <= '0;
    else if (en) pc <= pc + (br ? off_x[PC_W-1:0] : PC_W'(1));
endmodule

// File: rtl/ctrl_decode.sv
// ctrl_decode: fetch/execute sequencer and decoder; CTRL_ILLEGAL_TRAP_EN makes opcode 1111 a sticky-error halt
module ctrl_decode import core_pkg::*; #(parameter int PC_W = 8) (
  input logic clk,
  input logic rst_n,
  ctrl_decode_if.master bus
);
  logic [2:0] state, state_nx;
  logic [PC_W-1:0] pc;
  logic ovf_q, mem_we_q, t, in_exec, in_mem, go, is_ldst, is_halt, pc_en;
  opcode_e op;
  assign op = opcode_e'(bus.inst_in[7:4]);
  assign t = bus.inst_in[8];
  assign in_exec = state == S_EXEC;
  assign in_mem = state == S_MEM;
  assign go = bus.start && (state == S_IDLE || state == S_HALTED);
  assign is_ldst = !t && (op == OP_LOAD || op == OP_STORE);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign is_halt = !t && (op == OP_HALT || op == OP_TBA);
`else
  assign is_halt = !t && op == OP_HALT;
`endif
  assign pc_en = (in_exec && !is_ldst && !is_halt) || (in_mem && bus.mem_ack);
  ctrl_pc #(.PC_W(PC_W)) u_pc (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(pc_en),
    .br(in_exec && t && |bus.acc_in), .off(bus.inst_in[7:0]), .pc(pc)
  );
  // next state: START only acts from IDLE/HALTED, memory ops wait for ack
  always_comb
    state_nx = go ? S_FETCH :
      state == S_FETCH ? S_EXEC :
      in_exec ? (is_ldst ? S_MEM : is_halt ? S_HALTED : S_FETCH) :
      (in_mem && bus.mem_ack) ? S_FETCH : state;
  // state, overflow flag and latched store qualifier for the MEM wait
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ovf_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state <= state_nx;
      mem_we_q <= in_exec ? (!t && op == OP_STORE) : mem_we_q;
      ovf_q <= (state == S_HALTED && bus.start) ? 1'b0 :
        (in_exec && !t && op == OP_ADD) ? bus.alu_ovf_in :
        (in_exec && !t && op == OP_OF0) ? 1'b0 : ovf_q;
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q;
  // sticky illegal-opcode flag, cleared only by reset or a restart
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= go ? 1'b0 : (in_exec && !t && op == OP_TBA) ? 1'b1 : err_q;
  assign bus.err = err_q;
`endif
  assign bus.inst_addr = pc;
  assign bus.ovf = ovf_q;
  assign bus.type_bit = (in_exec || in_mem) && t;
  assign bus.alu_op = (in_exec || in_mem) ? bus.inst_in[7:4] : '0;
  assign bus.reg_sel = (in_exec || in_mem) ? bus.inst_in[3:0] : '0;
  assign bus.acc_we = (in_exec && !t && ACC_OP_MASK[bus.inst_in[7:4]]) || (in_mem && bus.mem_ack && !mem_we_q);
  assign bus.reg_we = in_exec && !t && op == OP_PUT;
  assign bus.mem_req = (in_exec && is_ldst) || in_mem;
  assign bus.mem_we = in_exec ? (!t && op == OP_STORE) : (in_mem && mem_we_q);
  assign bus.done = state == S_HALTED;
endmodule
